reg_swap_ctrl: RTL and testbench
================================

Name: reg_swap_ctrl

Overview:
Parametrised register-transfer controller with an internal NREG x WIDTH register file, a shared internal bus and one temp register. It executes swap, move and load operations under a start/busy/done handshake. Per-cycle bus-enable strobes (register out/in, temp out/in) are driven as Moore outputs so the datapath sequencing is observable. It serves as the general N-register successor to the fixed three-register swap sequencer.

Parameters:
WIDTH, 8, data width of each register, the temp register and the bus
NREG, 4, number of architectural registers (2..16)
IDXW, 2, index width; must satisfy 2**IDXW >= NREG

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 swap, 01 move src->dst, 10 load din->dst, 11 reserved
src_idx  input  IDXW  source register index
dst_idx  input  IDXW  destination register index
din  input  WIDTH  external load data
rd_idx  input  IDXW  read-port index
rd_data  output  WIDTH  combinational R[rd_idx]; 0 if rd_idx >= NREG
busy  output  1  high from the cycle after start is accepted through DONE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = op rejected, no writes
rout  output  NREG  one-hot: register driving bus
rin  output  NREG  one-hot: register loading from bus
tout  output  1  temp register driving bus
tin  output  1  temp register loading from bus
bus  output  WIDTH  current bus value; 0 when no driver

Behaviour:
- Single clock (clk); reset (rst) is asynchronous and active-high. On reset: state=IDLE; all R[i]=0, temp=0; busy, done, err, rout, rin, tout, tin = 0; bus = 0. Reset mid-operation aborts with no further writes.
- IDLE: when start=1 at a posedge, latch op, src, dst and din, then branch:
  - op=11, or any used index >= NREG -> DONE with err=1.
  - swap/move with src==dst -> DONE with err=0 and no writes.
  - swap -> X1; move -> X2; load -> XL.
- While not IDLE, start is ignored and latched fields are held.
- X1: rout[dst]=1, tin=1; temp<=R[dst]; next X2.
- X2: rout[src]=1, rin[dst]=1; R[dst]<=R[src]; next X3 for swap, DONE for move.
- X3: tout=1, rin[src]=1; R[src]<=temp; next DONE.
- XL: bus=din latched, rin[dst]=1; R[dst]<=din; next DONE.
- DONE: done=1, err per branch, busy=1, no strobes; next IDLE.
- Writes take effect at the posedge ending the state.
- Latency from start accepted to done pulse (cycles after the accepting edge): swap 4, move 2, load 2, rejected or null 1.
- Minimum start-to-start spacing is latency+1.
- Strobes are Moore outputs decoded from state and latched indices, with at most one bus driver per cycle.
- Register width is exactly WIDTH; no arithmetic; temp persists between ops.
- Default branch of every case returns to IDLE with all outputs 0.

Optional Feature:
Macro REG_SWAP_OPCNT_EN.
- Defined: adds output port op_count (16 bits). It resets to 0 and increments in every DONE cycle with err=0, wrapping 0xFFFF->0x0000.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then read all indices -> rd_data=0x00; busy=done=err=0; bus=0.
- Load R0=0xA5, R3=0x3C, then swap src=0 dst=3 -> done exactly 4 cycles after the accepting edge. Afterwards R0=0x3C, R3=0xA5, temp=0x3C. Strobe sequence: (rout[3],tin), (rout[0],rin[3]), (tout,rin[0]).
- Move src=3 dst=1 with R3=0xA5 -> done 2 cycles later with err=0; R1=0xA5 and R3 unchanged.
- op=11, src_idx=5 with NREG=4, and swap with src==dst -> each gives done 1 cycle later with err correct (1, 1, 0) and all registers unchanged.
- Pulse start again during an active swap, then assert rst in X2 -> the mid-op start has no effect; rst gives immediate IDLE, all registers 0, outputs 0.
- REG_SWAP_OPCNT_EN defined: 3 good ops plus 1 err op -> op_count=3. Preload the count to 0xFFFF via repeated ops, then one more op -> 0x0000.

Source files
------------

// File: rtl/reg_swap_ctrl.sv
// NREG x WIDTH register file with shared bus and temp: swap/move/load under start/busy/done; done 4/2/2/1 cycles after accept (swap/move/load/reject or null).
// start is ignored while busy; optional REG_SWAP_OPCNT_EN adds a 16-bit count of successful ops (op_count).
module reg_swap_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int IDXW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [IDXW-1:0]  src_idx,
  input  logic [IDXW-1:0]  dst_idx,
  input  logic [WIDTH-1:0] din,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NREG-1:0]  rout,
  output logic [NREG-1:0]  rin,
  output logic             tout,
  output logic             tin,
`ifdef REG_SWAP_OPCNT_EN
  output logic [15:0]      op_count,
`endif
  output logic [WIDTH-1:0] bus
);

  typedef enum logic [2:0] {S_IDLE, S_X1, S_X2, S_X3, S_XL, S_DONE} state_t;

  localparam logic [1:0]    OP_SWAP = 2'b00;
  localparam logic [1:0]    OP_LOAD = 2'b10;
  localparam logic [1:0]    OP_RSVD = 2'b11;
  // One extra bit so NREG == 2**IDXW is still representable.
  localparam logic [IDXW:0] NREG_W  = (IDXW+1)'(NREG);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [IDXW-1:0]  src_q, src_d, dst_q, dst_d;
  logic [WIDTH-1:0] din_q, din_d, temp_q, temp_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NREG-1:0]  rout_q, rout_d, rin_q, rin_d;
  logic             tout_q, tout_d, tin_q, tin_d;
  logic             rej_d, wr_en;
  logic [IDXW-1:0]  wr_idx;

  function automatic logic idx_ok(input logic [IDXW-1:0] idx);
    idx_ok = ({1'b0, idx} < NREG_W);
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [IDXW-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NREG; i++) onehot[i] = (idx == IDXW'(i));
  endfunction

  function automatic logic [WIDTH-1:0] rd_mux(input logic [WIDTH-1:0] r [NREG],
                                              input logic [IDXW-1:0]  idx);
    rd_mux = '0;
    for (int i = 0; i < NREG; i++)
      if (idx == IDXW'(i)) rd_mux = r[i];
  endfunction

  assign rd_data = rd_mux(regs_q, rd_idx);

  always_comb begin
    case (state_q)
      S_X1:    bus = rd_mux(regs_q, dst_q);
      S_X2:    bus = rd_mux(regs_q, src_q);
      S_X3:    bus = temp_q;
      S_XL:    bus = din_q;
      default: bus = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    din_d   = din_q;
    temp_d  = temp_q;
    regs_d  = regs_q;
    rej_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = dst_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          src_d = src_idx;
          dst_d = dst_idx;
          din_d = din;
          // Load has no source operand, so its src_idx is not range-checked.
          if (op == OP_RSVD || !idx_ok(dst_idx) || (op != OP_LOAD && !idx_ok(src_idx))) begin
            state_d = S_DONE;
            rej_d   = 1'b1;
          end else if (op != OP_LOAD && src_idx == dst_idx) begin
            state_d = S_DONE;
          end else if (op == OP_SWAP) begin
            state_d = S_X1;
          end else if (op == OP_LOAD) begin
            state_d = S_XL;
          end else begin
            state_d = S_X2;
          end
        end
      end
      S_X1: begin
        temp_d  = bus;
        state_d = S_X2;
      end
      S_X2: begin
        wr_en   = 1'b1;
        state_d = (op_q == OP_SWAP) ? S_X3 : S_DONE;
      end
      S_X3: begin
        wr_en   = 1'b1;
        wr_idx  = src_q;
        state_d = S_DONE;
      end
      S_XL: begin
        wr_en   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    for (int i = 0; i < NREG; i++)
      if (wr_en && wr_idx == IDXW'(i)) regs_d[i] = bus;
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = rej_d;
    rout_d = '0;
    rin_d  = '0;
    tout_d = 1'b0;
    tin_d  = 1'b0;
    case (state_d)
      S_X1: begin
        rout_d = onehot(dst_d);
        tin_d  = 1'b1;
      end
      S_X2: begin
        rout_d = onehot(src_d);
        rin_d  = onehot(dst_d);
      end
      S_X3: begin
        tout_d = 1'b1;
        rin_d  = onehot(src_d);
      end
      S_XL:           rin_d = onehot(dst_d);
      S_IDLE, S_DONE: begin end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      din_q   <= '0;
      temp_q  <= '0;
      regs_q  <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rout_q  <= '0;
      rin_q   <= '0;
      tout_q  <= 1'b0;
      tin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      din_q   <= din_d;
      temp_q  <= temp_d;
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rout_q  <= rout_d;
      rin_q   <= rin_d;
      tout_q  <= tout_d;
      tin_q   <= tin_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign rout = rout_q;
  assign rin  = rin_q;
  assign tout = tout_q;
  assign tin  = tin_q;

`ifdef REG_SWAP_OPCNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + 16'(done_q && !err_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_reg_swap_ctrl.sv
// Bench for reg_swap_ctrl (NREG=4, IDXW=3 so out-of-range indices are expressible); directed table,
// mid-op start/reset sequence, then random ops against a value-level register model.
module tb_reg_swap_ctrl;
  localparam int WIDTH = 8;
  localparam int NREG  = 4;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [1:0]       op;
  logic [IDXW-1:0]  src_idx, dst_idx, rd_idx;
  logic [WIDTH-1:0] din, rd_data, bus;
  logic             busy, done, err, tout, tin;
  logic [NREG-1:0]  rout, rin;
`ifdef REG_SWAP_OPCNT_EN
  logic [15:0]      op_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] m_regs [NREG];
  logic [15:0]      m_cnt;

  typedef struct {
    logic [1:0]       op;
    logic [IDXW-1:0]  src;
    logic [IDXW-1:0]  dst;
    logic [WIDTH-1:0] din;
    logic             exp_err;
    int               exp_lat;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  reg_swap_ctrl #(.WIDTH(WIDTH), .NREG(NREG), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_idx(src_idx), .dst_idx(dst_idx),
    .din(din), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .rout(rout), .rin(rin), .tout(tout), .tin(tin),
`ifdef REG_SWAP_OPCNT_EN
    .op_count(op_count),
`endif
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREG-1:0] oh(input logic [IDXW-1:0] i);
    oh = 4'b0001 << i;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_idx = IDXW'(i);
      #1;
      if (i < NREG) chk($sformatf("%s rd[%0d]", tag, i), 32'(rd_data), 32'(m_regs[i]));
      else          chk($sformatf("%s rd[%0d]", tag, i), 32'(rd_data), 32'h0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " done"}, 32'(done), 32'h0);
    chk({tag, " err"}, 32'(err), 32'h0);
    chk({tag, " strobes"}, 32'({rout, rin, tout, tin}), 32'h0);
    chk({tag, " bus"}, 32'(bus), 32'h0);
  endtask

  function automatic void expect_of(input logic [1:0] o, input logic [IDXW-1:0] s, d,
                                    output logic e, output int lat);
    e = (o == 2'b11) || (d >= NREG) || (o != 2'b10 && s >= NREG);
    if (e || (o != 2'b10 && s == d)) lat = 1;
    else if (o == 2'b00)             lat = 4;
    else                             lat = 2;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [IDXW-1:0] s, d, input logic [WIDTH-1:0] dv,
                        input logic exp_err, input int exp_lat, input string tag);
    logic [2*NREG+1:0] exp_sv;
    logic [WIDTH-1:0]  exp_bus, t;
    @(negedge clk);
    op = o; src_idx = s; dst_idx = d; din = dv; start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= exp_lat; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      exp_sv  = '0;
      exp_bus = '0;
      if (k < exp_lat) begin
        if (o == 2'b00 && k == 1)      begin exp_sv = {oh(d), 4'b0, 2'b01}; exp_bus = m_regs[d]; end
        else if (o == 2'b00 && k == 2) begin exp_sv = {oh(s), oh(d), 2'b00}; exp_bus = m_regs[s]; end
        else if (o == 2'b00 && k == 3) begin exp_sv = {4'b0, oh(s), 2'b10}; exp_bus = m_regs[d]; end
        else if (o == 2'b01)           begin exp_sv = {oh(s), oh(d), 2'b00}; exp_bus = m_regs[s]; end
        else if (o == 2'b10)           begin exp_sv = {4'b0, oh(d), 2'b00}; exp_bus = dv; end
      end
      chk($sformatf("%s c%0d busy", tag, k), 32'(busy), 32'h1);
      chk($sformatf("%s c%0d done", tag, k), 32'(done), 32'(k == exp_lat));
      chk($sformatf("%s c%0d err", tag, k), 32'(err), 32'((k == exp_lat) && exp_err));
      chk($sformatf("%s c%0d strobes", tag, k), 32'({rout, rin, tout, tin}), 32'(exp_sv));
      chk($sformatf("%s c%0d bus", tag, k), 32'(bus), 32'(exp_bus));
      // Scramble inputs (and maybe raise start) while busy; none of it may matter.
      start = (k < exp_lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 2'($urandom); src_idx = IDXW'($urandom); dst_idx = IDXW'($urandom); din = 8'($urandom);
    end
    if (!exp_err && exp_lat > 1) begin
      if (o == 2'b00) begin
        t = m_regs[d]; m_regs[d] = m_regs[s]; m_regs[s] = t;
      end else if (o == 2'b01) m_regs[d] = m_regs[s];
      else                     m_regs[d] = dv;
    end
    if (!exp_err) m_cnt = m_cnt + 16'd1;
    @(posedge clk);
    #1;
    check_idle_outputs({tag, " after"});
`ifdef REG_SWAP_OPCNT_EN
    chk({tag, " op_count"}, 32'(op_count), 32'(m_cnt));
`endif
    check_regs(tag);
  endtask

  initial begin
    logic       e;
    int         lat;
    logic [1:0] ro;
    logic [IDXW-1:0] rs, rd;

    rst = 1'b1; start = 1'b0; op = '0; src_idx = '0; dst_idx = '0; din = '0; rd_idx = '0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_cnt = '0;

    vecs[0] = '{op: 2'b10, src: 3'd0, dst: 3'd0, din: 8'hA5, exp_err: 1'b0, exp_lat: 2};
    vecs[1] = '{op: 2'b10, src: 3'd0, dst: 3'd3, din: 8'h3C, exp_err: 1'b0, exp_lat: 2};
    vecs[2] = '{op: 2'b00, src: 3'd0, dst: 3'd3, din: 8'h00, exp_err: 1'b0, exp_lat: 4};
    vecs[3] = '{op: 2'b01, src: 3'd3, dst: 3'd1, din: 8'h00, exp_err: 1'b0, exp_lat: 2};
    vecs[4] = '{op: 2'b11, src: 3'd0, dst: 3'd1, din: 8'h11, exp_err: 1'b1, exp_lat: 1};
    vecs[5] = '{op: 2'b01, src: 3'd5, dst: 3'd1, din: 8'h00, exp_err: 1'b1, exp_lat: 1};
    vecs[6] = '{op: 2'b00, src: 3'd2, dst: 3'd2, din: 8'h00, exp_err: 1'b0, exp_lat: 1};
    vecs[7] = '{op: 2'b10, src: 3'd0, dst: 3'd6, din: 8'h99, exp_err: 1'b1, exp_lat: 1};
    vecs[8] = '{op: 2'b10, src: 3'd7, dst: 3'd2, din: 8'h77, exp_err: 1'b0, exp_lat: 2};
    vecs[9] = '{op: 2'b00, src: 3'd1, dst: 3'd0, din: 8'h00, exp_err: 1'b0, exp_lat: 4};

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 10; v++)
      run_op(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].din, vecs[v].exp_err, vecs[v].exp_lat,
             $sformatf("vec%0d", v));

    // Absolute expectations after the table, independent of the model.
    rd_idx = 3'd0; #1; chk("table R0", 32'(rd_data), 32'hA5);
    rd_idx = 3'd1; #1; chk("table R1", 32'(rd_data), 32'h3C);
    rd_idx = 3'd2; #1; chk("table R2", 32'(rd_data), 32'h77);
    rd_idx = 3'd3; #1; chk("table R3", 32'(rd_data), 32'hA5);

    // Swap 1<->2, pulse a conflicting start in X1, then reset in the middle of X2.
    @(negedge clk);
    op = 2'b00; src_idx = 3'd1; dst_idx = 3'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("midop X1 strobes", 32'({rout, rin, tout, tin}), 32'({oh(3'd2), 4'b0, 2'b01}));
    @(negedge clk);
    op = 2'b10; dst_idx = 3'd0; din = 8'hEE; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("midop X2 strobes", 32'({rout, rin, tout, tin}), 32'({oh(3'd1), oh(3'd2), 2'b00}));
    chk("midop X2 bus", 32'(bus), 32'h3C);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midop rst");
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_cnt = '0;
    check_regs("midop rst");
`ifdef REG_SWAP_OPCNT_EN
    chk("midop rst op_count", 32'(op_count), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b10, 3'd0, 3'd1, 8'h5A, 1'b0, 2, "post rst load");

    for (int n = 0; n < 60; n++) begin
      ro = 2'($urandom_range(0, 3));
      rs = IDXW'($urandom_range(0, 4));
      rd = IDXW'($urandom_range(0, 4));
      expect_of(ro, rs, rd, e, lat);
      run_op(ro, rs, rd, 8'($urandom), e, lat, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
